// File: rtl/codec_cfg_pkg.sv
// Shared constants, table field layout and FSM encoding for the codec configuration sequencer.
package codec_cfg_pkg;

    localparam int unsigned EntryW  = 16;
    localparam int unsigned RegLsb  = 9;
    localparam int unsigned RegW    = 7;
    localparam int unsigned DataLsb = 0;
    localparam int unsigned DataW   = 9;
    localparam int unsigned IdxW    = 5;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StIssue    = 4'd1,
        StWait     = 4'd2,
        StSettle   = 4'd3,
        StNext     = 4'd4,
        StDone     = 4'd5,
        StFault    = 4'd6
`ifdef CODEC_CFG_MANUAL_EN
        ,
        StManIssue = 4'd7,
        StManWait  = 4'd8
`endif
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/codec_cfg_settle_timer.sv
// Down-counter that spends exactly Cycles clock cycles in the counting phase after a load.
module codec_cfg_settle_timer #(
    parameter int unsigned Cycles = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned Width = (Cycles > 0) ? $clog2(Cycles + 1) : 1;
    localparam logic [Width-1:0] LoadVal = Width'(Cycles);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Expiry on the last counting cycle so the owner leaves after exactly Cycles cycles.
    assign expired = en && (cnt_q == Width'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Replays a {reg, data} init table to an audio codec over an I2C write master, with retry,
// settle delay and fault reporting. Define CODEC_CFG_MANUAL_EN to forward manual writes in DONE.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]                  DEV_ADDR      = 7'b0011010,
    parameter int unsigned                 N_ENTRIES     = 6,
    parameter logic [EntryW*N_ENTRIES-1:0] INIT_TABLE    = {
        7'h09, 9'h001, 7'h07, 9'h00A, 7'h05, 9'h000,
        7'h04, 9'h012, 7'h06, 9'h010, 7'h0F, 9'h000},
    parameter int unsigned                 MAX_RETRY     = 3,
    parameter int unsigned                 SETTLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_start,
    output logic        i2c_start,
    output logic [6:0]  i2c_addr,
    output logic [6:0]  i2c_reg,
    output logic [8:0]  i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_err,
    output logic        busy,
    output logic        init_done,
    output logic        init_fault,
    output logic [4:0]  fault_index,
    output logic [7:0]  err_count,
    input  logic        man_valid,
    output logic        man_ready,
    input  logic [6:0]  man_reg,
    input  logic [8:0]  man_data,
    output logic        man_done,
    output logic        man_err
);

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_ENTRIES - 1);
    localparam logic [7:0]      MaxRetry = 8'(MAX_RETRY);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        retry_q, retry_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              init_done_q, init_done_d;
    logic              init_fault_q, init_fault_d;
    logic [IdxW-1:0]   fault_index_q, fault_index_d;
    logic [RegW-1:0]   i2c_reg_q, i2c_reg_d;
    logic [DataW-1:0]  i2c_data_q, i2c_data_d;
    logic              restart;
    logic              settle_load;
    logic              settle_expired;

    codec_cfg_settle_timer #(
        .Cycles (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (settle_load),
        .en      (state_q == StSettle),
        .expired (settle_expired)
    );

`ifndef CODEC_CFG_MANUAL_EN
    logic unused_man;
    assign unused_man = ^{man_valid, man_reg, man_data};
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        err_count_d   = err_count_q;
        init_done_d   = init_done_q;
        init_fault_d  = init_fault_q;
        fault_index_d = fault_index_q;
        i2c_reg_d     = i2c_reg_q;
        i2c_data_d    = i2c_data_q;
        restart       = 1'b0;
        settle_load   = 1'b0;
        i2c_start     = 1'b0;
        busy          = 1'b1;
        man_ready     = 1'b0;
        man_done      = 1'b0;
        man_err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                restart = init_start;
            end
            StIssue: begin
                i2c_start = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                if (i2c_done) begin
                    if (i2c_err) begin
                        err_count_d = sat_inc8(err_count_q);
                        if (retry_q < MaxRetry) begin
                            retry_d = retry_q + 8'd1;
                            state_d = StIssue;
                        end else begin
                            fault_index_d = idx_q;
                            init_fault_d  = 1'b1;
                            state_d       = StFault;
                        end
                    end else begin
                        retry_d = '0;
                        if (SETTLE_CYCLES > 0) begin
                            settle_load = 1'b1;
                            state_d     = StSettle;
                        end else begin
                            state_d = StNext;
                        end
                    end
                end
            end
            StSettle: begin
                if (settle_expired) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    init_done_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                busy    = 1'b0;
                restart = init_start;
`ifdef CODEC_CFG_MANUAL_EN
                // A restart request takes priority over a pending manual write.
                man_ready = !init_start;
                if (man_valid && !init_start) begin
                    i2c_reg_d  = man_reg;
                    i2c_data_d = man_data;
                    state_d    = StManIssue;
                end
`endif
            end
            StFault: begin
                busy    = 1'b0;
                restart = init_start;
            end
`ifdef CODEC_CFG_MANUAL_EN
            StManIssue: begin
                i2c_start = 1'b1;
                state_d   = StManWait;
            end
            StManWait: begin
                if (i2c_done) begin
                    man_done = 1'b1;
                    man_err  = i2c_err;
                    if (i2c_err) begin
                        err_count_d = sat_inc8(err_count_q);
                    end
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (restart) begin
            idx_d        = '0;
            retry_d      = '0;
            init_done_d  = 1'b0;
            init_fault_d = 1'b0;
            state_d      = StIssue;
        end

        // Fields are captured on entry to ISSUE and held through the master's transaction.
        if (state_d == StIssue) begin
            i2c_reg_d  = INIT_TABLE[EntryW*idx_d + RegLsb +: RegW];
            i2c_data_d = INIT_TABLE[EntryW*idx_d + DataLsb +: DataW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            retry_q       <= '0;
            err_count_q   <= '0;
            init_done_q   <= 1'b0;
            init_fault_q  <= 1'b0;
            fault_index_q <= '0;
            i2c_reg_q     <= '0;
            i2c_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            err_count_q   <= err_count_d;
            init_done_q   <= init_done_d;
            init_fault_q  <= init_fault_d;
            fault_index_q <= fault_index_d;
            i2c_reg_q     <= i2c_reg_d;
            i2c_data_q    <= i2c_data_d;
        end
    end

    assign i2c_addr    = DEV_ADDR;
    assign i2c_reg     = i2c_reg_q;
    assign i2c_data    = i2c_data_q;
    assign init_done   = init_done_q;
    assign init_fault  = init_fault_q;
    assign fault_index = fault_index_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Randomised bench for codec_cfg_sequencer: an I2C master model with scripted NACKs and a
// table-level reference model of the expected write sequence, fault point and error count.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;

    localparam int unsigned NEnt     = 6;
    localparam int unsigned Settle   = 1000;
    localparam int unsigned MaxRetry = 3;
    localparam logic [6:0]  DevAddr  = 7'b0011010;
    localparam logic [95:0] Table    = {7'h09, 9'h001, 7'h07, 9'h00A, 7'h05, 9'h000,
                                        7'h04, 9'h012, 7'h06, 9'h010, 7'h0F, 9'h000};

    logic [6:0] tbl_reg [NEnt] = '{7'h0F, 7'h06, 7'h04, 7'h05, 7'h07, 7'h09};
    logic [8:0] tbl_dat [NEnt] = '{9'h000, 9'h010, 9'h012, 9'h000, 9'h00A, 9'h001};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       init_start, i2c_start, m_done, m_err, spur_done, busy, init_done, init_fault;
    logic [6:0] i2c_addr, i2c_reg, man_reg;
    logic [8:0] i2c_data, man_data;
    logic [4:0] fault_index;
    logic [7:0] err_count;
    logic       man_valid, man_ready, man_done, man_err;

    codec_cfg_sequencer #(
        .DEV_ADDR      (DevAddr),
        .N_ENTRIES     (NEnt),
        .INIT_TABLE    (Table),
        .MAX_RETRY     (MaxRetry),
        .SETTLE_CYCLES (Settle)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .init_start  (init_start),
        .i2c_start   (i2c_start),
        .i2c_addr    (i2c_addr),
        .i2c_reg     (i2c_reg),
        .i2c_data    (i2c_data),
        .i2c_done    (m_done | spur_done),
        .i2c_err     (m_err | spur_done),
        .busy        (busy),
        .init_done   (init_done),
        .init_fault  (init_fault),
        .fault_index (fault_index),
        .err_count   (err_count),
        .man_valid   (man_valid),
        .man_ready   (man_ready),
        .man_reg     (man_reg),
        .man_data    (man_data),
        .man_done    (man_done),
        .man_err     (man_err)
    );

    // Minimal instance: one entry, no settle, no retry.
    logic       init_start_m, i2c_start_m, done_m, err_m, busy_m, init_done_m, init_fault_m;
    logic [6:0] i2c_addr_m, i2c_reg_m;
    logic [8:0] i2c_data_m;
    logic [4:0] fault_index_m;
    logic [7:0] err_count_m;
    logic       man_ready_m, man_done_m, man_err_m;

    codec_cfg_sequencer #(
        .DEV_ADDR      (DevAddr),
        .N_ENTRIES     (1),
        .INIT_TABLE    ({7'h55, 9'h1AA}),
        .MAX_RETRY     (0),
        .SETTLE_CYCLES (0)
    ) u_dut_min (
        .clk         (clk),
        .rst         (rst),
        .init_start  (init_start_m),
        .i2c_start   (i2c_start_m),
        .i2c_addr    (i2c_addr_m),
        .i2c_reg     (i2c_reg_m),
        .i2c_data    (i2c_data_m),
        .i2c_done    (done_m),
        .i2c_err     (err_m),
        .busy        (busy_m),
        .init_done   (init_done_m),
        .init_fault  (init_fault_m),
        .fault_index (fault_index_m),
        .err_count   (err_count_m),
        .man_valid   (1'b0),
        .man_ready   (man_ready_m),
        .man_reg     (7'h00),
        .man_data    (9'h000),
        .man_done    (man_done_m),
        .man_err     (man_err_m)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // I2C master model: records every write, answers after a random latency.
    logic [15:0] obs_q[$];
    int          gap_q[$];
    int          nack_left[128];
    int          cyc = 0;
    int          pend = 0;
    logic        pend_err = 1'b0;
    bit          prev_ok = 1'b0;
    int          last_ok_cyc = 0;

    initial begin
        m_done = 1'b0;
        m_err  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!rst) begin
                pend    = 0;
                prev_ok = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        m_done      = 1'b1;
                        m_err       = pend_err;
                        prev_ok     = !pend_err;
                        last_ok_cyc = cyc;
                    end
                end
                if (i2c_start) begin
                    obs_q.push_back({i2c_reg, i2c_data});
                    if (prev_ok) gap_q.push_back(cyc - last_ok_cyc);
                    prev_ok  = 1'b0;
                    pend     = $urandom_range(2, 9);
                    pend_err = (nack_left[i2c_reg] > 0);
                    if (pend_err) nack_left[i2c_reg]--;
                end
            end
        end
    end

    // Reference model: per-entry NACK counts -> expected writes, fault point, errors.
    int          nacks[NEnt];
    logic [15:0] exp_q[$];
    bit          exp_fault;
    int          exp_fidx;
    int          exp_gaps;
    int          exp_err_total = 0;

    task automatic build_expect();
        int run_errs;
        int ok_writes;
        int tries;
        exp_q.delete();
        exp_fault = 1'b0;
        exp_fidx  = 0;
        run_errs  = 0;
        ok_writes = 0;
        for (int i = 0; i < NEnt; i++) begin
            tries = (nacks[i] > MaxRetry) ? MaxRetry + 1 : nacks[i] + 1;
            for (int t = 0; t < tries; t++) exp_q.push_back({tbl_reg[i], tbl_dat[i]});
            if (nacks[i] > MaxRetry) begin
                run_errs += MaxRetry + 1;
                exp_fault = 1'b1;
                exp_fidx  = i;
                break;
            end
            run_errs += nacks[i];
            ok_writes++;
        end
        exp_gaps      = exp_fault ? ok_writes : ok_writes - 1;
        exp_err_total = (exp_err_total + run_errs > 255) ? 255 : exp_err_total + run_errs;
    endtask

    task automatic clear_nacks();
        for (int i = 0; i < NEnt; i++) nacks[i] = 0;
    endtask

    task automatic run_main(input string tag, input bit poke, input bit with_man);
        int n;
        int poke_at;
        build_expect();
        for (int i = 0; i < 128; i++) nack_left[i] = 0;
        for (int i = 0; i < NEnt; i++) nack_left[tbl_reg[i]] = nacks[i];
        obs_q.delete();
        gap_q.delete();
        prev_ok = 1'b0;
        poke_at = $urandom_range(10, 3000);
        init_start = 1'b1;
        if (with_man) begin
            man_valid = 1'b1;
            man_reg   = 7'h05;
            man_data  = 9'h008;
            check_eq({tag, " man_ready vs init_start"}, man_ready, 1'b0);
        end
        tick();
        init_start = 1'b0;
        man_valid  = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            if (poke && n == poke_at) init_start = 1'b1;
            tick();
            init_start = 1'b0;
            n++;
        end
        check_eq({tag, " finished"}, busy, 1'b0);
        repeat (20) tick();
        check_eq({tag, " n_writes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq({tag, $sformatf(" write%0d", i)}, obs_q[i], exp_q[i]);
        check_eq({tag, " n_gaps"}, gap_q.size(), exp_gaps);
        for (int i = 0; i < gap_q.size(); i++)
            check_eq({tag, " settle gap"}, gap_q[i], Settle + 2);
        check_eq({tag, " init_done"}, init_done, !exp_fault);
        check_eq({tag, " init_fault"}, init_fault, exp_fault);
        if (exp_fault) check_eq({tag, " fault_index"}, fault_index, exp_fidx);
        check_eq({tag, " err_count"}, err_count, exp_err_total);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, " i2c_start"}, i2c_start, 1'b0);
        check_eq({tag, " i2c_addr"}, i2c_addr, DevAddr);
        check_eq({tag, " i2c_reg/data"}, {i2c_reg, i2c_data}, 16'h0000);
        check_eq({tag, " busy"}, busy, 1'b0);
        check_eq({tag, " done/fault"}, {init_done, init_fault}, 2'b00);
        check_eq({tag, " fault_index"}, fault_index, 5'd0);
        check_eq({tag, " err_count"}, err_count, 8'd0);
        check_eq({tag, " man outs"}, {man_ready, man_done, man_err}, 3'b000);
    endtask

`ifdef CODEC_CFG_MANUAL_EN
    task automatic man_write(input string tag, input logic [6:0] r, input logic [8:0] d,
                             input bit nack);
        int n;
        nack_left[r] = nack ? 1 : 0;
        obs_q.delete();
        check_eq({tag, " man_ready"}, man_ready, 1'b1);
        man_valid = 1'b1;
        man_reg   = r;
        man_data  = d;
        tick();
        man_valid = 1'b0;
        check_eq({tag, " busy"}, busy, 1'b1);
        n = 0;
        while (!man_done && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, " man_done"}, man_done, 1'b1);
        check_eq({tag, " man_err"}, man_err, nack);
        tick();
        check_eq({tag, " man_done pulse"}, man_done, 1'b0);
        if (nack) exp_err_total = (exp_err_total == 255) ? 255 : exp_err_total + 1;
        check_eq({tag, " err_count"}, err_count, exp_err_total);
        check_eq({tag, " n_writes"}, obs_q.size(), 1);
        if (obs_q.size() > 0) check_eq({tag, " fields"}, obs_q[0], {r, d});
        check_eq({tag, " back in done"}, {busy, init_done}, 2'b01);
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        init_start   = 1'b0;
        man_valid    = 1'b0;
        man_reg      = '0;
        man_data     = '0;
        spur_done    = 1'b0;
        init_start_m = 1'b0;
        done_m       = 1'b0;
        err_m        = 1'b0;
        for (int i = 0; i < 128; i++) nack_left[i] = 0;
        repeat (3) tick();
        reset_checks("reset");
        rst = 1'b1;
        tick();

        clear_nacks();
        run_main("t1 clean", 1'b0, 1'b0);
        clear_nacks();
        nacks[2] = 2;
        run_main("t2 nack2x2", 1'b0, 1'b0);
        clear_nacks();
        nacks[4] = 4;
        run_main("t3 fault4", 1'b0, 1'b1);
        clear_nacks();
        run_main("t3 restart", 1'b0, 1'b0);

        // A done pulse while idle in DONE must be ignored and not counted.
        obs_q.delete();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        repeat (3) tick();
        check_eq("spurious done err_count", err_count, exp_err_total);
        check_eq("spurious done state", {busy, init_done}, 2'b01);
        check_eq("spurious done writes", obs_q.size(), 0);

        // Reset in the middle of entry 3's transaction.
        for (int i = 0; i < 128; i++) nack_left[i] = 0;
        obs_q.delete();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0;
        while (obs_q.size() < 4 && n < 10000) begin
            tick();
            n++;
        end
        check_eq("t4 reached entry3", obs_q.size(), 4);
        tick();
        rst = 1'b0;
        #1;
        reset_checks("t4 async");
        tick();
        reset_checks("t4 held");
        rst = 1'b1;
        exp_err_total = 0;
        tick();
        clear_nacks();
        run_main("t4 replay", 1'b0, 1'b0);

`ifdef CODEC_CFG_MANUAL_EN
        man_write("t5 ack", 7'h05, 9'h008, 1'b0);
        man_write("t5 nack", 7'h05, 9'h008, 1'b1);
`else
        obs_q.delete();
        man_valid = 1'b1;
        man_reg   = 7'h05;
        man_data  = 9'h008;
        repeat (4) begin
            check_eq("t5 man_ready off", man_ready, 1'b0);
            tick();
        end
        man_valid = 1'b0;
        repeat (10) tick();
        check_eq("t5 no manual write", obs_q.size(), 0);
        check_eq("t5 man_done off", {man_done, man_err}, 2'b00);
        check_eq("t5 still done", {busy, init_done}, 2'b01);
`endif

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NEnt; i++)
                nacks[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_main($sformatf("rand%0d", r), 1'b1, 1'b0);
        end

        // Single-entry instance: init_done two cycles after the ack, immediate fault on NACK.
        init_start_m = 1'b1;
        tick();
        init_start_m = 1'b0;
        n = 0;
        while (!i2c_start_m && n < 10) begin
            tick();
            n++;
        end
        check_eq("t6 start", i2c_start_m, 1'b1);
        check_eq("t6 fields", {i2c_reg_m, i2c_data_m}, {7'h55, 9'h1AA});
        repeat (3) tick();
        done_m = 1'b1;
        tick();
        done_m = 1'b0;
        check_eq("t6 done +1", init_done_m, 1'b0);
        tick();
        check_eq("t6 done +2", init_done_m, 1'b1);
        check_eq("t6 busy", busy_m, 1'b0);
        init_start_m = 1'b1;
        tick();
        init_start_m = 1'b0;
        check_eq("t6 restart clears done", init_done_m, 1'b0);
        repeat (2) tick();
        done_m = 1'b1;
        err_m  = 1'b1;
        tick();
        done_m = 1'b0;
        err_m  = 1'b0;
        check_eq("t6 fault", {init_fault_m, init_done_m, busy_m}, 3'b100);
        check_eq("t6 fault_index", fault_index_m, 5'd0);
        check_eq("t6 err_count", err_count_m, 8'd1);
        check_eq("t6 man outs", {man_ready_m, man_done_m, man_err_m, i2c_start_m}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
